// File: rtl/scan_resp_pkg.sv
// Shared types and address-map constants for the scan request responder.
package scan_resp_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned SPACE_BIT  = 11;
    localparam int unsigned REG_IDX_W  = 6;
    localparam int unsigned MEM_ADDR_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        REG_ACK,
        MEM_ISSUE,
        MEM_WAIT,
        MEM_ACK
    } state_t;

endpackage

// File: rtl/scan_cfg_regbank.sv
// Configuration register bank: indexed write, combinational read mux,
// unmapped-index detection and a flattened view of all registers.
module scan_cfg_regbank
    import scan_resp_pkg::*;
#(
    parameter int unsigned         REG_NUM   = 16,
    parameter logic [DATA_W-1:0]   BAD_RDATA = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [REG_IDX_W-1:0]        idx,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        unmapped,
    output logic [REG_NUM*DATA_W-1:0]   cfg_regs
);

    logic [DATA_W-1:0] regs [REG_NUM];

    // Extra MSB keeps the compare meaningful when REG_NUM is 64.
    assign unmapped = ({1'b0, idx} >= (REG_IDX_W + 1)'(REG_NUM));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !unmapped) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                if (idx == REG_IDX_W'(i)) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (unmapped) begin
            rdata = BAD_RDATA;
        end else begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                if (idx == REG_IDX_W'(i)) begin
                    rdata = regs[i];
                end
            end
        end
    end

    always_comb begin
        cfg_regs = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            cfg_regs[i*DATA_W +: DATA_W] = regs[i];
        end
    end

endmodule

// File: rtl/scan_reg_mem_resp.sv
// Scan request responder: services single-cycle read/write pulses from the
// internal register bank or a fixed-latency SRAM, answering with scan_ready.
module scan_reg_mem_resp
    import scan_resp_pkg::*;
#(
    parameter int unsigned   REG_NUM     = 16,
    parameter int unsigned   MEM_LATENCY = 2,
    parameter logic [31:0]   BAD_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        scan_wen,
    input  logic                        scan_ren,
    input  logic [ADDR_W-1:0]           scan_addr,
    input  logic [DATA_W-1:0]           scan_wdata,
    output logic [DATA_W-1:0]           scan_rdata,
    output logic                        scan_ready,
    output logic                        mem_ce,
    output logic                        mem_we,
    output logic [MEM_ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [REG_NUM*DATA_W-1:0]   cfg_regs,
    output logic                        err_flag
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   rdata_q;

    logic                req;
    logic                accept;
    logic                is_mem;
    logic                reg_wr;
    logic [DATA_W-1:0]   reg_rdata;
    logic                reg_unmapped;

    assign req    = scan_wen | scan_ren;
    assign accept = req && (state == IDLE);
    assign is_mem = scan_addr[SPACE_BIT];
    assign reg_wr = accept && !is_mem && scan_wen;

    scan_cfg_regbank #(
        .REG_NUM   (REG_NUM),
        .BAD_RDATA (BAD_RDATA)
    ) u_regbank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (reg_wr),
        .idx      (scan_addr[REG_IDX_W-1:0]),
        .wdata    (scan_wdata),
        .rdata    (reg_rdata),
        .unmapped (reg_unmapped),
        .cfg_regs (cfg_regs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        mem_ce     = 1'b0;
        scan_ready = 1'b0;
        scan_rdata = '0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = is_mem ? MEM_ISSUE : REG_ACK;
                end
            end
            REG_ACK: begin
                scan_ready = 1'b1;
                scan_rdata = rdata_q;
                state_nx   = IDLE;
            end
            MEM_ISSUE: begin
                mem_ce   = 1'b1;
                state_nx = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = MEM_ACK;
                end
            end
            MEM_ACK: begin
                scan_ready = 1'b1;
                scan_rdata = rdata_q;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read data is captured at acceptance for registers and at the end of
    // the wait window for memory, so the ACK states only present rdata_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            err_flag  <= 1'b0;
        end else begin
            if (accept) begin
                if (is_mem) begin
                    mem_we    <= scan_wen;
                    mem_addr  <= scan_addr[MEM_ADDR_W-1:0];
                    mem_wdata <= scan_wdata;
                end else begin
                    rdata_q <= scan_wen ? '0 : reg_rdata;
                end
            end
            if (state == MEM_ISSUE) begin
                wait_cnt <= CNT_W'(MEM_LATENCY - 1);
            end else if (state == MEM_WAIT) begin
                if (wait_cnt == '0) begin
                    rdata_q <= mem_we ? '0 : mem_rdata;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
            if ((req && state != IDLE) || (accept && !is_mem && reg_unmapped)) begin
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_reg_mem_resp.sv
// Scoreboard bench for scan_reg_mem_resp with a fixed-latency SRAM model.
module tb_scan_reg_mem_resp;

    localparam int unsigned REG_NUM     = 16;
    localparam int unsigned MEM_LATENCY = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    scan_wen = 1'b0;
    logic                    scan_ren = 1'b0;
    logic [11:0]             scan_addr = '0;
    logic [31:0]             scan_wdata = '0;
    logic [31:0]             scan_rdata;
    logic                    scan_ready;
    logic                    mem_ce;
    logic                    mem_we;
    logic [10:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic [31:0]             mem_rdata = '0;
    logic [REG_NUM*32-1:0]   cfg_regs;
    logic                    err_flag;

    int                      checks = 0;
    int                      errors = 0;
    int                      cyc = 0;
    int                      ce_count = 0;
    logic [31:0]             erd_q[$];
    int                      ecyc_q[$];
    logic [31:0]             exp_regs [REG_NUM];
    logic [31:0]             mem_model [2048];
    int                      mdel = 0;
    logic [31:0]             mdata = '0;

    scan_reg_mem_resp #(
        .REG_NUM     (REG_NUM),
        .MEM_LATENCY (MEM_LATENCY),
        .BAD_RDATA   (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_wen   (scan_wen),
        .scan_ren   (scan_ren),
        .scan_addr  (scan_addr),
        .scan_wdata (scan_wdata),
        .scan_rdata (scan_rdata),
        .scan_ready (scan_ready),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .cfg_regs   (cfg_regs),
        .err_flag   (err_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SRAM model: data is valid only during cycle ce+MEM_LATENCY, garbage otherwise.
    always @(negedge clk) begin
        mem_rdata = 32'hBAD0_BAD0;
        if (mdel > 0) begin
            mdel--;
            if (mdel == 0) mem_rdata = mdata;
        end
        if (mem_ce) begin
            if (mem_we) mem_model[mem_addr] = mem_wdata;
            mdata = mem_we ? 32'hBAD0_BAD0 : mem_model[mem_addr];
            mdel  = MEM_LATENCY;
        end
    end

    // Scoreboard monitor: every scan_ready must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_ce) ce_count++;
            checks++;
            if (scan_ready) begin
                if (erd_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready cyc=%0d rdata=%h required no ready", cyc, scan_rdata);
                end else begin
                    logic [31:0] e;
                    int          c;
                    e = erd_q.pop_front();
                    c = ecyc_q.pop_front();
                    if (scan_rdata !== e || cyc !== c) begin
                        errors++;
                        $display("FAIL ready_data cyc=%0d rdata=%h required cyc=%0d rdata=%h", cyc, scan_rdata, c, e);
                    end
                end
            end else if (scan_rdata !== 32'h0) begin
                errors++;
                $display("FAIL rdata_idle cyc=%0d rdata=%h required 0", cyc, scan_rdata);
            end
        end
    end

    function automatic logic [REG_NUM*32-1:0] exp_flat();
        logic [REG_NUM*32-1:0] v;
        v = '0;
        for (int i = 0; i < REG_NUM; i++) v[i*32 +: 32] = exp_regs[i];
        return v;
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        scan_wen = 1'b0;
        scan_ren = 1'b0;
        erd_q.delete();
        ecyc_q.delete();
        for (int i = 0; i < REG_NUM; i++) exp_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one request pulse in cycle T and checks the SRAM strobe in T+1.
    task automatic issue(input logic wen, input logic ren, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] erd, input bit push);
        int lat;
        @(posedge clk); #1;
        scan_wen   = wen;
        scan_ren   = ren;
        scan_addr  = addr;
        scan_wdata = wdata;
        lat = addr[11] ? 2 + MEM_LATENCY : 1;
        if (push) begin
            erd_q.push_back(erd);
            ecyc_q.push_back(cyc + lat);
        end
        if (!addr[11] && wen && addr[5:0] < REG_NUM) exp_regs[addr[5:0]] = wdata;
        @(posedge clk); #1;
        scan_wen   = 1'b0;
        scan_ren   = 1'b0;
        scan_addr  = 12'($urandom);
        scan_wdata = $urandom;
        @(negedge clk);
        checks++;
        if (mem_ce !== addr[11]) begin
            errors++;
            $display("FAIL mem_ce addr=%h got=%b required=%b", addr, mem_ce, addr[11]);
        end
        if (addr[11]) begin
            checks++;
            if (mem_addr !== addr[10:0] || mem_we !== wen || (wen && mem_wdata !== wdata)) begin
                errors++;
                $display("FAIL mem_issue got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                         mem_addr, mem_we, mem_wdata, addr[10:0], wen, wdata);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (erd_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (erd_q.size() != 0) begin
            errors++;
            $display("FAIL ready_timeout pending=%0d required 0", erd_q.size());
            erd_q.delete();
            ecyc_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (scan_ready !== 1'b0 || scan_rdata !== 32'h0 || mem_ce !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 11'h0 || mem_wdata !== 32'h0 || err_flag !== 1'b0 || cfg_regs !== '0) begin
            errors++;
            $display("FAIL reset_state rdy=%b rd=%h ce=%b we=%b ma=%h mw=%h err=%b required all zero",
                     scan_ready, scan_rdata, mem_ce, mem_we, mem_addr, mem_wdata, err_flag);
        end
    endtask

    task automatic test_reg_rw();
        issue(1'b1, 1'b0, 12'h003, 32'hA5A5_0001, 32'h0, 1'b1);
        wait_done();
        issue(1'b0, 1'b1, 12'h003, 32'h0, 32'hA5A5_0001, 1'b1);
        wait_done();
        issue(1'b1, 1'b0, 12'h00F, 32'h0F0F_1234, 32'h0, 1'b1);
        wait_done();
        issue(1'b0, 1'b1, 12'h00F, 32'h0, 32'h0F0F_1234, 1'b1);
        issue(1'b0, 1'b1, 12'h007, 32'h0, 32'h0, 1'b1);
        wait_done();
        checks++;
        if (cfg_regs[127:96] !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL cfg_reg3 got=%h required=%h", cfg_regs[127:96], 32'hA5A5_0001);
        end
        checks++;
        if (cfg_regs !== exp_flat()) begin
            errors++;
            $display("FAIL cfg_regs_after_rw got=%h required=%h", cfg_regs, exp_flat());
        end
    endtask

    task automatic test_mem_read();
        mem_model[11'h005] = 32'h1234_5678;
        issue(1'b0, 1'b1, 12'h805, 32'h0, 32'h1234_5678, 1'b1);
        wait_done();
    endtask

    task automatic test_mem_write();
        issue(1'b1, 1'b0, 12'hFFF, 32'hCAFE_F00D, 32'h0, 1'b1);
        wait_done();
        checks++;
        if (mem_model[11'h7FF] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL mem_write_stored got=%h required=%h", mem_model[11'h7FF], 32'hCAFE_F00D);
        end
        issue(1'b0, 1'b1, 12'hFFF, 32'h0, 32'hCAFE_F00D, 1'b1);
        wait_done();
        checks++;
        if (err_flag !== 1'b0) begin
            errors++;
            $display("FAIL err_clean got=%b required=0", err_flag);
        end
    endtask

    task automatic test_unmapped();
        issue(1'b0, 1'b1, 12'h020, 32'h0, 32'hDEAD_BEEF, 1'b1);
        wait_done();
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL err_unmapped got=%b required=1", err_flag);
        end
        issue(1'b1, 1'b0, 12'h010, 32'h7777_7777, 32'h0, 1'b1);
        wait_done();
        checks++;
        if (cfg_regs !== exp_flat()) begin
            errors++;
            $display("FAIL cfg_unmapped got=%h required=%h", cfg_regs, exp_flat());
        end
    endtask

    task automatic test_back_to_back_drop();
        int ce0;
        apply_reset();
        mem_model[11'h001] = 32'h0BAD_CAFE;
        mem_model[11'h002] = 32'h2222_2222;
        ce0 = ce_count;
        issue(1'b0, 1'b1, 12'h801, 32'h0, 32'h0BAD_CAFE, 1'b1);
        @(posedge clk); #1;
        scan_wen   = 1'b1;
        scan_addr  = 12'h802;
        scan_wdata = 32'h9999_9999;
        @(posedge clk); #1;
        scan_wen = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        checks++;
        if (ce_count - ce0 !== 1) begin
            errors++;
            $display("FAIL drop_ce_count got=%0d required=1", ce_count - ce0);
        end
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL err_drop got=%b required=1", err_flag);
        end
        checks++;
        if (mem_model[11'h002] !== 32'h2222_2222) begin
            errors++;
            $display("FAIL drop_mem got=%h required=%h", mem_model[11'h002], 32'h2222_2222);
        end
    endtask

    task automatic test_both_and_abort();
        apply_reset();
        issue(1'b1, 1'b1, 12'h001, 32'h0000_0005, 32'h0, 1'b1);
        wait_done();
        checks++;
        if (cfg_regs[63:32] !== 32'h5) begin
            errors++;
            $display("FAIL both_write got=%h required=%h", cfg_regs[63:32], 32'h5);
        end
        issue(1'b0, 1'b1, 12'h806, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < REG_NUM; i++) exp_regs[i] = '0;
        @(negedge clk);
        checks++;
        if (scan_ready !== 1'b0 || scan_rdata !== 32'h0 || mem_ce !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 11'h0 || mem_wdata !== 32'h0 || err_flag !== 1'b0 || cfg_regs !== '0) begin
            errors++;
            $display("FAIL abort_state rdy=%b rd=%h ce=%b we=%b ma=%h mw=%h err=%b required all zero",
                     scan_ready, scan_rdata, mem_ce, mem_we, mem_addr, mem_wdata, err_flag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(1'b0, 1'b1, 12'h001, 32'h0, 32'h0, 1'b1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
        for (int i = 0; i < REG_NUM; i++) exp_regs[i] = '0;
        test_reset();
        test_reg_rw();
        test_mem_read();
        test_mem_write();
        test_unmapped();
        test_back_to_back_drop();
        test_both_and_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
